// File: rtl/stat_engine_pkg.sv
// Shared types and helpers for the pet statistics engine.
package stat_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DEAD = 2'd2
    } state_e;

    // Width of the statistic index / action id for n statistics.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..TICK_COUNT-1 counter; tick is high while the count sits at its last value.
module tick_prescaler #(
    parameter int unsigned TICK_COUNT = 24'd10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CNT_W = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = (count_q == CNT_LAST) ? '0 : count_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == CNT_LAST);

endmodule

// File: rtl/stat_engine.sv
// Pet statistics engine: saturating feed actions in IDLE, randomised one-stat-per-cycle
// decay scan on every prescaler tick, and a DEAD state left only through revive.
module stat_engine
    import stat_engine_pkg::*;
#(
    parameter int                 NUM_STATS  = 6,
    parameter int                 STAT_W     = 4,
    parameter int unsigned        TICK_COUNT = 24'd10_000_000,
    parameter logic [STAT_W-1:0]  INIT_VAL   = {STAT_W{1'b1}}
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              action_valid,
    output logic                              action_ready,
    input  logic [idx_width(NUM_STATS)-1:0]   action_id,
    input  logic [STAT_W-1:0]                 action_amt,
    input  logic [7:0]                        rand_in,
    input  logic                              revive,
    output logic [NUM_STATS*STAT_W-1:0]       stats_flat,
    output logic [NUM_STATS-1:0]              critical,
    output logic                              alive,
    output logic                              tick_o
);

    localparam int                ID_W     = idx_width(NUM_STATS);
    localparam logic [ID_W-1:0]   IDX_ONE  = ID_W'(1);
    localparam logic [ID_W-1:0]   IDX_LAST = ID_W'(NUM_STATS - 1);
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   scan_idx_q, scan_idx_d;
    logic [STAT_W-1:0] stat_q [NUM_STATS];
    logic [STAT_W-1:0] stat_d [NUM_STATS];
    logic              action_ready_q, action_ready_d;
    logic              alive_q, alive_d;
    logic              tick;
    logic              any_zero;
    logic              dec;
    logic              unused_rand;

    // Only the low NUM_STATS bits of rand_in steer decay when NUM_STATS < 8.
    assign unused_rand = ^rand_in;

    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                  input logic [STAT_W-1:0] b);
        logic [STAT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
    endfunction

    tick_prescaler #(
        .TICK_COUNT (TICK_COUNT)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Health takes an extra hit whenever any other statistic is exhausted.
    always_comb begin
        any_zero = 1'b0;
        for (int i = 1; i < NUM_STATS; i++) begin
            if (stat_q[i] == '0) any_zero = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        scan_idx_d = scan_idx_q;
        dec        = 1'b0;
        for (int i = 0; i < NUM_STATS; i++) stat_d[i] = stat_q[i];

        case (state_q)
            ST_IDLE: begin
                if (action_valid) begin
                    for (int i = 0; i < NUM_STATS; i++) begin
                        if (action_id == ID_W'(i)) stat_d[i] = sat_add(stat_q[i], action_amt);
                    end
                end
                if (tick) begin
                    state_d    = ST_SCAN;
                    scan_idx_d = '0;
                end
            end
            ST_SCAN: begin
                for (int i = 0; i < NUM_STATS; i++) begin
                    if (scan_idx_q == ID_W'(i)) begin
                        if (i == 0) dec = any_zero | rand_in[0];
                        else        dec = rand_in[i % 8];
                        if (dec && stat_q[i] != '0) stat_d[i] = stat_q[i] - STAT_ONE;
                    end
                end
                if (scan_idx_q == IDX_LAST) begin
                    scan_idx_d = '0;
                    state_d    = (stat_d[0] == '0) ? ST_DEAD : ST_IDLE;
                end else begin
                    scan_idx_d = scan_idx_q + IDX_ONE;
                end
            end
            ST_DEAD: begin
                if (revive) begin
                    for (int i = 0; i < NUM_STATS; i++) stat_d[i] = INIT_VAL;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                scan_idx_d = '0;
            end
        endcase

        action_ready_d = (state_d == ST_IDLE);
        alive_d        = (state_d != ST_DEAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            scan_idx_q     <= '0;
            action_ready_q <= 1'b1;
            alive_q        <= 1'b1;
            for (int i = 0; i < NUM_STATS; i++) stat_q[i] <= INIT_VAL;
        end else begin
            state_q        <= state_d;
            scan_idx_q     <= scan_idx_d;
            action_ready_q <= action_ready_d;
            alive_q        <= alive_d;
            for (int i = 0; i < NUM_STATS; i++) stat_q[i] <= stat_d[i];
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_STATS; gi++) begin : g_out
            assign stats_flat[gi*STAT_W +: STAT_W] = stat_q[gi];
            assign critical[gi]                    = (stat_q[gi] == '0);
        end
    endgenerate

    assign action_ready = action_ready_q;
    assign alive        = alive_q;
    assign tick_o       = tick;

endmodule

// File: tb/tb_stat_engine.sv
// Directed scoreboard bench for stat_engine (4 stats x 4 bits, 16-cycle tick, init 8).
module tb_stat_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        action_valid = 1'b0;
    logic        action_ready;
    logic [1:0]  action_id = '0;
    logic [3:0]  action_amt = '0;
    logic [7:0]  rand_in = '0;
    logic        revive = 1'b0;
    logic [15:0] stats_flat;
    logic [3:0]  critical;
    logic        alive;
    logic        tick_o;

    logic        a5_valid = 1'b0;
    logic        a5_ready;
    logic [2:0]  a5_id = '0;
    logic [3:0]  a5_amt = '0;
    logic [19:0] s5_flat;
    logic [4:0]  crit5;
    logic        alive5;
    logic        tick5;

    int checks = 0;
    int failures = 0;
    int m [4];
    logic [15:0] sb_q [$];
    string       sb_tag [$];
    int n, lows, guard, prev;

    always #5 clk = ~clk;

    stat_engine #(
        .NUM_STATS (4), .STAT_W (4), .TICK_COUNT (16), .INIT_VAL (4'd8)
    ) u_dut (
        .clk (clk), .rst_n (rst_n), .action_valid (action_valid), .action_ready (action_ready),
        .action_id (action_id), .action_amt (action_amt), .rand_in (rand_in), .revive (revive),
        .stats_flat (stats_flat), .critical (critical), .alive (alive), .tick_o (tick_o)
    );

    // Five-stat instance gives a 3-bit id so out-of-range ids can actually be driven.
    stat_engine #(
        .NUM_STATS (5), .STAT_W (4), .TICK_COUNT (4000), .INIT_VAL (4'd8)
    ) u_dut5 (
        .clk (clk), .rst_n (rst_n), .action_valid (a5_valid), .action_ready (a5_ready),
        .action_id (a5_id), .action_amt (a5_amt), .rand_in (rand_in), .revive (1'b0),
        .stats_flat (s5_flat), .critical (crit5), .alive (alive5), .tick_o (tick5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        $display("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_flat();
        return {4'(m[3]), 4'(m[2]), 4'(m[1]), 4'(m[0])};
    endfunction

    task automatic sb_push(input string tag);
        sb_q.push_back(model_flat());
        sb_tag.push_back(tag);
    endtask

    task automatic sb_check();
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            chk(sb_tag.pop_front(), stats_flat, sb_q.pop_front());
        end
    endtask

    function automatic void model_add(input int id, input int amt);
        m[id] = (m[id] + amt > 15) ? 15 : m[id] + amt;
    endfunction

    function automatic void model_scan(input logic [7:0] r);
        bit az;
        az = (m[1] == 0) || (m[2] == 0) || (m[3] == 0);
        if ((az || r[0]) && m[0] > 0) m[0]--;
        for (int i = 1; i < 4; i++) if (r[i] && m[i] > 0) m[i]--;
    endfunction

    task automatic wait_tick();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!tick_o && k < 40);
        chk("tick_seen", tick_o, 1);
    endtask

    // Called on the negedge where tick_o is high; ends on the negedge after the scan.
    task automatic finish_scan(input logic [7:0] r, output int lo);
        lo = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            action_valid = 1'b0;
            if (!action_ready) lo++;
        end
        model_scan(r);
        sb_push("scan_result");
        sb_check();
        chk("alive_after_scan", alive, m[0] != 0);
    endtask

    task automatic tick_scan(input logic [7:0] r, input bit act_en, input int aid, input int aamt,
                             output int lo);
        rand_in = r;
        wait_tick();
        if (act_en) begin
            chk("ready_on_tick_cycle", action_ready, 1);
            action_valid = 1'b1;
            action_id    = aid[1:0];
            action_amt   = aamt[3:0];
            model_add(aid, aamt);
        end
        finish_scan(r, lo);
    endtask

    task automatic act(input int id, input int amt);
        chk("ready_idle", action_ready, 1);
        action_valid = 1'b1;
        action_id    = id[1:0];
        action_amt   = amt[3:0];
        model_add(id, amt);
        sb_push("action_result");
        @(posedge clk);
        #1 action_valid = 1'b0;
        @(negedge clk);
        sb_check();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) m[i] = 8;

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        chk("rst_stats", stats_flat, 16'h8888);
        chk("rst_alive", alive, 1);
        chk("rst_tick", tick_o, 0);
        chk("rst_ready", action_ready, 1);
        chk("rst_critical", critical, 4'b0000);

        // First tick 15 cycles after release.
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick_o && n < 40);
        chk("first_tick_latency", n, 15);
        chk("post_rst_stats", stats_flat, 16'h8888);

        // Quiet scan: nothing decays with rand_in=0 and no empty stat.
        finish_scan(8'h00, lows);
        chk("scan_ready_low_cycles", lows, 4);

        // Full decay scan.
        tick_scan(8'hFF, 1'b0, 0, 0, lows);
        chk("scan_ff_ready_low_cycles", lows, 4);
        chk("scan_ff_flat", stats_flat, 16'h7777);
        rand_in = 8'h00;

        // Saturating and zero-amount actions, then a revive outside DEAD.
        act(2, 9);
        chk("sat_stat2", stats_flat[11:8], 4'hF);
        act(1, 3);
        act(3, 0);
        revive = 1'b1;
        @(posedge clk);
        #1 revive = 1'b0;
        @(negedge clk);
        sb_push("revive_ignored");
        sb_check();
        chk("revive_ignored_alive", alive, 1);

        // Out-of-range ids are accepted and ignored.
        a5_valid = 1'b1;
        a5_id    = 3'd5;
        a5_amt   = 4'd3;
        chk("id5_ready", a5_ready, 1);
        @(negedge clk);
        chk("id5_ignored", s5_flat, 20'h88888);
        a5_id = 3'd7;
        @(negedge clk);
        chk("id7_ignored", s5_flat, 20'h88888);
        a5_id = 3'd4;
        @(negedge clk);
        a5_valid = 1'b0;
        chk("id4_applied", s5_flat, 20'hB8888);

        // Action in the tick cycle, then drain stat3 to zero with bit 3 only.
        tick_scan(8'h08, 1'b1, 1, 2, lows);
        guard = 0;
        while (m[3] != 0 && guard < 12) begin
            tick_scan(8'h08, 1'b0, 0, 0, lows);
            guard++;
        end
        chk("critical_stat3", critical, 4'b1000);

        // Health decays because stat3 is empty even with rand_in=0.
        prev = m[0];
        tick_scan(8'h00, 1'b0, 0, 0, lows);
        chk("health_dec_on_zero", stats_flat[3:0], 4'(prev - 1));
        chk("others_unchanged", stats_flat[15:4], {4'(m[3]), 4'(m[2]), 4'(m[1])});

        // Decay health to zero.
        guard = 0;
        while (m[0] != 0 && guard < 20) begin
            tick_scan(8'hFF, 1'b0, 0, 0, lows);
            guard++;
        end
        chk("dead_alive", alive, 0);
        chk("dead_ready", action_ready, 0);
        chk("dead_critical0", critical[0], 1);

        // Actions refused and ticks ignored while dead.
        action_valid = 1'b1;
        action_id    = 2'd1;
        action_amt   = 4'd5;
        @(negedge clk);
        action_valid = 1'b0;
        sb_push("dead_action_refused");
        sb_check();
        wait_tick();
        repeat (6) @(negedge clk);
        sb_push("dead_frozen");
        sb_check();
        chk("dead_still", alive, 0);

        // Revive.
        revive = 1'b1;
        @(posedge clk);
        #1 revive = 1'b0;
        for (int i = 0; i < 4; i++) m[i] = 8;
        @(negedge clk);
        sb_push("revived");
        sb_check();
        chk("revive_alive", alive, 1);
        chk("revive_ready", action_ready, 1);

        // Reset on the second SCAN cycle discards the partial decay.
        rand_in = 8'hFF;
        wait_tick();
        @(negedge clk);
        @(negedge clk);
        chk("partial_scan", stats_flat, 16'h8887);
        chk("partial_scan_ready", action_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("midscan_rst_stats", stats_flat, 16'h8888);
        chk("midscan_rst_alive", alive, 1);
        chk("midscan_rst_tick", tick_o, 0);
        chk("midscan_rst_ready", action_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_midscan_stats", stats_flat, 16'h8888);
        chk("post_midscan_ready", action_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
